clock_reset_seq: RTL and testbench
==================================

// Module: clock_reset_seq
// PURPOSE
//  Parametrised clock-enable and reset sequencer for the clock tree behind the MMCME2_ADV/BUFG pair.
//  Watches PLL lock, waits for lock to be stable, then releases NUM_CH per-domain resets in staggered order.
//  Generates one programmable-divide clock-enable strobe per domain.
//  Divide ratios are set at runtime through a PipeIn-style enq interface.
//  On loss of lock it re-asserts all domain resets.
// PARAMETERS
//  NUM_CH        3   number of reset/clock-enable domains (1..16)
//  DIV_W         8   width of each divide value
//  STABLE_CYCLES 16  consecutive synced-lock cycles required before first release (>=1)
//  STAGGER       4   cycles between successive domain releases (>=1)
//  DEF_DIV       0   divide value loaded into every channel at reset
// PORTS
//  CLK          in   1                    single clock; all logic on rising edge
//  RST          in   1                    synchronous, active-high reset
//  locked       in   1                    PLL LOCKED, asynchronous to CLK
//  enq__ENA     in   1                    config write strobe
//  enq$v        in   CIW+DIV_W            {channel index[CIW-1:0], divide[DIV_W-1:0]}; CIW=max(1,$clog2(NUM_CH))
//  enq__RDY     out  1                    config write accepted this cycle
//  rst_out      out  NUM_CH               per-domain reset, active-high
//  clk_en       out  NUM_CH               per-domain clock-enable strobe
//  ready        out  1                    all domains out of reset
//  lock_lost    out  1                    sticky: lock dropped after first release; cleared only by RST
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset values: rst_out all 1; clk_en 0; ready 0; lock_lost 0; enq__RDY 0; div[i] = DEF_DIV; FSM = WAIT_LOCK.
//  locked passes through a 2-flop synchroniser (lk_s) before any use; no other CDC.
//  FSM states:
//   WAIT_LOCK: wait for lk_s=1, then go to STABLE with stable counter=1.
//   STABLE:    increment the counter while lk_s=1.
//              At STABLE_CYCLES, go to RELEASE, idx=0.
//   RELEASE:   clear rst_out[idx] at the entry edge and then every STAGGER cycles, idx++.
//              After clearing rst_out[NUM_CH-1], go to RUN.
//   RUN:       hold; ready=1 (registered, same edge as the last rst_out falls).
//  Lock drop: lk_s=0 in STABLE, RELEASE or RUN means next edge sets rst_out all 1, ready=0, FSM=WAIT_LOCK.
//   lock_lost is set only if any rst_out bit was already 0.
//  Timing: locked rising sampled at edge t gives lk_s=1 at t+2.
//   rst_out[0] falls at edge t+1+STABLE_CYCLES.
//   rst_out[k] falls STAGGER*k edges later.
//  Divider i: cnt[i] is held at 0 while rst_out[i]=1.
//   clk_en[i] = (cnt[i]==div[i]) & ~rst_out[i], combinational from registered state.
//   When clk_en[i]=1, cnt[i] wraps to 0; otherwise it increments.
//   Period is div+1 cycles; div=0 gives clk_en constantly 1 once released.
//  Config: enq__RDY = ~RST_state & (FSM != RELEASE); a write happens when enq__ENA & enq__RDY.
//   A write updates div[ch] and clears cnt[ch] on the same edge.
//   The new period starts on the following cycle.
//   A channel index >= NUM_CH is accepted and ignored (no state change).
//   enq__ENA while enq__RDY=0 is dropped; the sender must hold it.
//  Simultaneous events:
//   lock drop and config write in the same cycle: the write lands, the resets still assert.
//   RST asserted mid-sequence: every register returns to its reset value at the next edge, including div and lock_lost.
// TESTING
//  NUM_CH=3, STABLE_CYCLES=16, STAGGER=4, DEF_DIV=0.
//  1. locked rises at edge 10 -> rst_out[0] falls at 27, [1] at 31, [2] at 35; ready=1 from 35; clk_en[0]=1 from 27.
//  2. locked drops for 1 cycle at edge 20 (before release) -> no release; sequence restarts.
//     lock_lost stays 0; rst_out[0] falls 17 edges after lock returns.
//  3. In RUN, write {ch=1, div=3} -> clk_en[1] pulses every 4th cycle.
//     First pulse 4 cycles after the write edge; ch0 and ch2 unaffected.
//  4. Write ch=3 (invalid) in RUN -> accepted (enq__RDY=1); all div and clk_en unchanged.
//  5. Drop locked in RUN -> 3 edges later rst_out=3'b111, clk_en=0, ready=0, lock_lost=1.
//     On relock the full sequence repeats; lock_lost stays 1 until RST.
//  6. Assert RST during RELEASE (after rst_out[0] falls) -> next edge all outputs at reset values and div back to 0.

Source files
------------

// File: rtl/clock_reset_seq.sv
// Clock-enable and reset sequencer: waits for a stable PLL lock, releases per-domain
// resets in staggered order and generates one programmable-divide enable strobe per domain.
module clock_reset_seq #(
  parameter int NUM_CH        = 3,
  parameter int DIV_W         = 8,
  parameter int STABLE_CYCLES = 16,
  parameter int STAGGER       = 4,
  parameter int DEF_DIV       = 0,
  localparam int CIW          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   locked,
  input  logic                   enq__ENA,
  input  logic [CIW+DIV_W-1:0]   enq__v,
  output logic                   enq__RDY,
  output logic [NUM_CH-1:0]      rst_out,
  output logic [NUM_CH-1:0]      clk_en,
  output logic                   ready,
  output logic                   lock_lost
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int GW = (STAGGER > 1) ? $clog2(STAGGER) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_e;

  state_e              state_q, state_d;
  logic [SW-1:0]       stb_q, stb_d;
  logic [GW-1:0]       stg_q, stg_d;
  logic [CIW-1:0]      idx_q, idx_d;
  logic [NUM_CH-1:0]   rst_out_q, rst_out_d;
  logic                ready_q, ready_d;
  logic                lost_q, lost_d;
  logic                lk_meta_q, lk_s_q;
  logic                rst_state_q;
  logic                rel_now;
  logic [CIW-1:0]      rel_idx;

  logic                wr_en;
  logic [CIW-1:0]      wr_ch;
  logic [DIV_W-1:0]    wr_div;

  assign enq__RDY  = ~rst_state_q & (state_q != RELEASE);
  assign wr_en     = enq__ENA & enq__RDY;
  assign wr_ch     = enq__v[CIW+DIV_W-1:DIV_W];
  assign wr_div    = enq__v[DIV_W-1:0];
  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign lock_lost = lost_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= WAIT_LOCK;
      stb_q       <= '0;
      stg_q       <= '0;
      idx_q       <= '0;
      rst_out_q   <= '1;
      ready_q     <= 1'b0;
      lost_q      <= 1'b0;
      lk_meta_q   <= 1'b0;
      lk_s_q      <= 1'b0;
      rst_state_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      stg_q       <= stg_d;
      idx_q       <= idx_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      lost_q      <= lost_d;
      lk_meta_q   <= locked;
      lk_s_q      <= lk_meta_q;
      rst_state_q <= 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    stb_d     = stb_q;
    stg_d     = stg_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    lost_d    = lost_q;
    rel_now   = 1'b0;
    rel_idx   = idx_q;

    // Losing lock anywhere past WAIT_LOCK overrides any release step in flight.
    if (!lk_s_q && (state_q != WAIT_LOCK)) begin
      state_d   = WAIT_LOCK;
      rst_out_d = '1;
      ready_d   = 1'b0;
      if (!(&rst_out_q)) begin
        lost_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          if (lk_s_q) begin
            if (STABLE_CYCLES == 1) begin
              rel_now = 1'b1;
              rel_idx = '0;
            end else begin
              state_d = STABLE;
              stb_d   = SW'(1);
            end
          end
        end
        STABLE: begin
          if (stb_q == SW'(STABLE_CYCLES - 1)) begin
            rel_now = 1'b1;
            rel_idx = '0;
          end else begin
            stb_d = stb_q + SW'(1);
          end
        end
        RELEASE: begin
          if (stg_q == GW'(STAGGER - 1)) begin
            rel_now = 1'b1;
          end else begin
            stg_d = stg_q + GW'(1);
          end
        end
        RUN: begin
        end
        default: state_d = WAIT_LOCK;
      endcase

      if (rel_now) begin
        rst_out_d[rel_idx] = 1'b0;
        idx_d              = rel_idx + CIW'(1);
        stg_d              = '0;
        if (rel_idx == CIW'(NUM_CH - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
        end else begin
          state_d = RELEASE;
        end
      end
    end
  end

  // Per-domain divider; an index >= NUM_CH matches no channel and is silently absorbed.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_div
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             hit;
    logic             wr_hit;

    assign hit        = (cnt_q == div_q) & ~rst_out_q[gi];
    assign wr_hit     = wr_en & (wr_ch == CIW'(gi));
    assign clk_en[gi] = hit;

    always_comb begin
      div_d = div_q;
      cnt_d = cnt_q + DIV_W'(1);
      if (rst_out_q[gi] || hit) begin
        cnt_d = '0;
      end
      if (wr_hit) begin
        div_d = wr_div;
        cnt_d = '0;
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        div_q <= DIV_W'(DEF_DIV);
        cnt_q <= '0;
      end else begin
        div_q <= div_d;
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_clock_reset_seq.sv
// Bench for clock_reset_seq: timed vectors {inputs, expected outputs} keyed by edge number,
// expectations queued when driven and compared just after the edge that produces them.
module tb_clock_reset_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       locked = 1'b0;
  logic       enq_ena = 1'b0;
  logic [9:0] enq_v = '0;
  logic       enq_rdy;
  logic [2:0] rst_out;
  logic [2:0] clk_en;
  logic       ready;
  logic       lock_lost;

  clock_reset_seq #(
    .NUM_CH(3), .DIV_W(8), .STABLE_CYCLES(16), .STAGGER(4), .DEF_DIV(0)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .locked(locked),
    .enq__ENA(enq_ena),
    .enq__v(enq_v),
    .enq__RDY(enq_rdy),
    .rst_out(rst_out),
    .clk_en(clk_en),
    .ready(ready),
    .lock_lost(lock_lost)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         at;
    logic       rst_i;
    logic       lk;
    logic       ena;
    logic [1:0] ch;
    logic [7:0] dv;
    logic [2:0] e_rst;
    logic [2:0] e_en;
    logic       e_ready;
    logic       e_lost;
    logic       e_rdy;
    string      nm;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   e;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input int at, input logic rst_i, input logic lk, input logic ena,
                              input logic [1:0] ch, input logic [7:0] dv, input logic [2:0] e_rst,
                              input logic [2:0] e_en, input logic e_ready, input logic e_lost,
                              input logic e_rdy, input string nm);
    vec_t v;
    v.at = at; v.rst_i = rst_i; v.lk = lk; v.ena = ena; v.ch = ch; v.dv = dv;
    v.e_rst = e_rst; v.e_en = e_en; v.e_ready = e_ready; v.e_lost = e_lost; v.e_rdy = e_rdy;
    v.nm = nm;
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    e++;
    #1;
  endtask

  // Inputs of v are sampled at edge v.at; expected values describe the state after that edge.
  task automatic apply(input vec_t v);
    vec_t x;
    while (e < v.at - 1) tick();
    RST     = v.rst_i;
    locked  = v.lk;
    enq_ena = v.ena;
    enq_v   = {v.ch, v.dv};
    exp_q.push_back(v);
    tick();
    RST     = 1'b0;
    enq_ena = 1'b0;
    x = exp_q.pop_front();
    n_vec++;
    if (rst_out !== x.e_rst || clk_en !== x.e_en || ready !== x.e_ready ||
        lock_lost !== x.e_lost || enq_rdy !== x.e_rdy) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got rst_out=%b clk_en=%b ready=%b lock_lost=%b enq__RDY=%b, want rst_out=%b clk_en=%b ready=%b lock_lost=%b enq__RDY=%b",
               x.nm, e, rst_out, clk_en, ready, lock_lost, enq_rdy,
               x.e_rst, x.e_en, x.e_ready, x.e_lost, x.e_rdy);
    end else begin
      $display("ok   %s @edge %0d: rst_out=%b clk_en=%b ready=%b lock_lost=%b enq__RDY=%b",
               x.nm, e, rst_out, clk_en, ready, lock_lost, enq_rdy);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got no summary, want finish before 20000ns");
    $fatal(1);
  end

  initial begin
    // Segment 1: reset, first lock, staggered release, config writes, lock loss and relock.
    //          at  rst lk ena ch  dv   rst_out clk_en rdy lost enqrdy
    tbl.push_back(mk( 0, 1, 0, 0, 0, 0, 3'b111, 3'b000, 0, 0, 0, "reset_state"));
    tbl.push_back(mk( 1, 0, 0, 0, 0, 0, 3'b111, 3'b000, 0, 0, 1, "idle_wait_lock"));
    tbl.push_back(mk(10, 0, 1, 0, 0, 0, 3'b111, 3'b000, 0, 0, 1, "lock_rise"));
    tbl.push_back(mk(26, 0, 1, 0, 0, 0, 3'b111, 3'b000, 0, 0, 1, "pre_release"));
    tbl.push_back(mk(27, 0, 1, 0, 0, 0, 3'b110, 3'b001, 0, 0, 0, "rel_ch0"));
    tbl.push_back(mk(30, 0, 1, 0, 0, 0, 3'b110, 3'b001, 0, 0, 0, "pre_rel_ch1"));
    tbl.push_back(mk(31, 0, 1, 0, 0, 0, 3'b100, 3'b011, 0, 0, 0, "rel_ch1"));
    tbl.push_back(mk(34, 0, 1, 0, 0, 0, 3'b100, 3'b011, 0, 0, 0, "pre_rel_ch2"));
    tbl.push_back(mk(35, 0, 1, 0, 0, 0, 3'b000, 3'b111, 1, 0, 1, "rel_ch2_ready"));
    tbl.push_back(mk(40, 0, 1, 1, 1, 3, 3'b000, 3'b101, 1, 0, 1, "wr_ch1_div3"));
    tbl.push_back(mk(41, 0, 1, 0, 0, 0, 3'b000, 3'b101, 1, 0, 1, "div3_c1"));
    tbl.push_back(mk(42, 0, 1, 0, 0, 0, 3'b000, 3'b101, 1, 0, 1, "div3_c2"));
    tbl.push_back(mk(43, 0, 1, 0, 0, 0, 3'b000, 3'b111, 1, 0, 1, "div3_pulse1"));
    tbl.push_back(mk(44, 0, 1, 0, 0, 0, 3'b000, 3'b101, 1, 0, 1, "div3_wrap"));
    tbl.push_back(mk(47, 0, 1, 0, 0, 0, 3'b000, 3'b111, 1, 0, 1, "div3_pulse2"));
    tbl.push_back(mk(50, 0, 1, 1, 3, 5, 3'b000, 3'b101, 1, 0, 1, "wr_invalid_ch3"));
    tbl.push_back(mk(51, 0, 1, 0, 0, 0, 3'b000, 3'b111, 1, 0, 1, "after_invalid_pulse"));
    tbl.push_back(mk(52, 0, 1, 0, 0, 0, 3'b000, 3'b101, 1, 0, 1, "after_invalid_wrap"));
    tbl.push_back(mk(60, 0, 0, 0, 0, 0, 3'b000, 3'b101, 1, 0, 1, "lock_drop_e1"));
    tbl.push_back(mk(61, 0, 0, 0, 0, 0, 3'b000, 3'b101, 1, 0, 1, "lock_drop_e2"));
    tbl.push_back(mk(62, 0, 0, 0, 0, 0, 3'b111, 3'b000, 0, 1, 1, "lock_drop_reset"));
    tbl.push_back(mk(70, 0, 1, 0, 0, 0, 3'b111, 3'b000, 0, 1, 1, "relock"));
    tbl.push_back(mk(87, 0, 1, 0, 0, 0, 3'b110, 3'b001, 0, 1, 0, "rerel_ch0"));
    tbl.push_back(mk(91, 0, 1, 0, 0, 0, 3'b100, 3'b001, 0, 1, 0, "rerel_ch1_div3"));
    tbl.push_back(mk(94, 0, 1, 0, 0, 0, 3'b100, 3'b011, 0, 1, 0, "rerel_ch1_pulse"));
    tbl.push_back(mk(95, 0, 1, 0, 0, 0, 3'b000, 3'b101, 1, 1, 1, "rerel_ready"));

    e = -1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Segment 2: one-cycle lock glitch before release, dropped write in RELEASE,
    // RST mid-release restoring div, then lock drop coinciding with a config write.
    e = -1;
    apply(mk( 0, 1, 0, 0, 0, 0, 3'b111, 3'b000, 0, 0, 0, "reset_clears_lost"));
    apply(mk( 5, 0, 0, 1, 0, 1, 3'b111, 3'b000, 0, 0, 1, "wr_ch0_div1_waitlock"));
    apply(mk(10, 0, 1, 0, 0, 0, 3'b111, 3'b000, 0, 0, 1, "lock_rise2"));
    apply(mk(20, 0, 0, 0, 0, 0, 3'b111, 3'b000, 0, 0, 1, "glitch_low"));
    apply(mk(21, 0, 1, 0, 0, 0, 3'b111, 3'b000, 0, 0, 1, "glitch_back"));
    apply(mk(27, 0, 1, 0, 0, 0, 3'b111, 3'b000, 0, 0, 1, "no_early_release"));
    apply(mk(37, 0, 1, 0, 0, 0, 3'b111, 3'b000, 0, 0, 1, "pre_release2"));
    apply(mk(38, 0, 1, 0, 0, 0, 3'b110, 3'b000, 0, 0, 0, "rel_ch0_div1"));
    apply(mk(39, 0, 1, 1, 0, 5, 3'b110, 3'b001, 0, 0, 0, "wr_dropped_in_release"));
    apply(mk(40, 1, 1, 0, 0, 0, 3'b111, 3'b000, 0, 0, 0, "rst_mid_release"));
    apply(mk(41, 0, 1, 0, 0, 0, 3'b111, 3'b000, 0, 0, 1, "post_rst_idle"));
    apply(mk(58, 0, 1, 0, 0, 0, 3'b110, 3'b001, 0, 0, 0, "rel_ch0_div_restored"));
    apply(mk(59, 0, 1, 0, 0, 0, 3'b110, 3'b001, 0, 0, 0, "div0_constant"));
    apply(mk(66, 0, 1, 0, 0, 0, 3'b000, 3'b111, 1, 0, 1, "run2"));
    apply(mk(70, 0, 0, 0, 0, 0, 3'b000, 3'b111, 1, 0, 1, "drop2_e1"));
    apply(mk(72, 0, 0, 1, 2, 1, 3'b111, 3'b000, 0, 1, 1, "drop_with_wr_ch2"));
    apply(mk(75, 0, 1, 0, 0, 0, 3'b111, 3'b000, 0, 1, 1, "relock2"));
    apply(mk(92, 0, 1, 0, 0, 0, 3'b110, 3'b001, 0, 1, 0, "rerel2_ch0"));
    apply(mk(100, 0, 1, 0, 0, 0, 3'b000, 3'b011, 1, 1, 1, "wr_landed_ch2_c0"));
    apply(mk(101, 0, 1, 0, 0, 0, 3'b000, 3'b111, 1, 1, 1, "wr_landed_ch2_pulse"));
    apply(mk(102, 0, 1, 0, 0, 0, 3'b000, 3'b011, 1, 1, 1, "wr_landed_ch2_wrap"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
